csr_timer_intc: RTL

Parametrised timer and interrupt-collection unit for the LoongArch CSR space. It owns ECFG, ESTAT.IS, TID, TCFG, TVAL and TICLR, plus an optional 64-bit stable counter. It synchronises N_HWI hardware interrupt lines, generates the timer interrupt, and delivers a registered interrupt-pending flag to the exception logic. It sits beside the main CSR file, which forwards these addresses here and muxes `csr_rdata` when `csr_hit` is high.

---
 rtl/csr_timer_intc_if.sv | 30 +++
 rtl/csr_timer_intc.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/csr_timer_intc_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_timer_intc_if
// Description : CSR access bundle between the main CSR file (master) and the
//               timer / interrupt-collection unit (slave).
//   csr_we     master->slave  write strobe, already qualified
//   csr_addr   master->slave  14-bit CSR number
//   csr_wdata  master->slave  32-bit write data, already masked
//   csr_rdata  slave->master  combinational read data, 0 when not hit
//   csr_hit    slave->master  address belongs to this unit
// Revision    : 1.0  initial release
// ============================================================================
interface csr_timer_intc_if;
  logic        csr_we;
  logic [13:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_hit;

  modport master (
    output csr_we, csr_addr, csr_wdata,
    input  csr_rdata, csr_hit
  );

  modport slave (
    input  csr_we, csr_addr, csr_wdata,
    output csr_rdata, csr_hit
  );
endinterface
`default_nettype wire

// File: rtl/csr_timer_intc.sv
`default_nettype none
// ============================================================================
// Module      : csr_timer_intc
// Description : LoongArch CSR timer and interrupt-collection unit. Owns ECFG,
//               ESTAT.IS, TID, TCFG, TVAL and TICLR, synchronises the
//               hardware interrupt lines, generates the timer interrupt and
//               registers the interrupt-pending flag for the exception logic.
//               Optional 64-bit stable counter enabled by defining the macro
//               CSR_TIMER_STABLE_CNT_EN (otherwise cnt_lo/cnt_hi are 0).
// Ports       :
//   clk          clock
//   reset        synchronous active-high reset
//   csr          CSR access bundle (slave side)
//   hwi          asynchronous level interrupt lines, IS[2+N_HWI-1:2]
//   ipi          inter-processor interrupt level, IS[12]
//   crmd_ie      global interrupt enable (CRMD.IE)
//   int_pending  registered |(LIE & IS) & crmd_ie
//   cnt_lo/hi    stable counter bits 31:0 / 63:32
// Revision    : 1.0  initial release
// ============================================================================
module csr_timer_intc #(
  parameter int TIMER_W     = 32,
  parameter int N_HWI       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CORE_ID     = 0
) (
  input  wire logic                                clk,
  input  wire logic                                reset,
  csr_timer_intc_if.slave                          csr,
  input  wire logic [((N_HWI > 0) ? N_HWI : 1)-1:0] hwi,
  input  wire logic                                ipi,
  input  wire logic                                crmd_ie,
  output logic                                     int_pending,
  output logic [31:0]                              cnt_lo,
  output logic [31:0]                              cnt_hi
);

  localparam int c_hwi_w = (N_HWI > 0) ? N_HWI : 1;

  localparam logic [13:0] c_addr_ecfg  = 14'h004;
  localparam logic [13:0] c_addr_estat = 14'h005;
  localparam logic [13:0] c_addr_tid   = 14'h040;
  localparam logic [13:0] c_addr_tcfg  = 14'h041;
  localparam logic [13:0] c_addr_tval  = 14'h042;
  localparam logic [13:0] c_addr_ticlr = 14'h044;

  // LIE bit 10 has no interrupt source behind it and is held at 0.
  localparam logic [12:0]        c_lie_mask = 13'h1BFF;
  localparam logic [TIMER_W-1:0] c_tval_one = TIMER_W'(1);

  // Address decode
  logic w_sel_ecfg, w_sel_estat, w_sel_tid, w_sel_tcfg, w_sel_tval, w_sel_ticlr;
  assign w_sel_ecfg  = (csr.csr_addr == c_addr_ecfg);
  assign w_sel_estat = (csr.csr_addr == c_addr_estat);
  assign w_sel_tid   = (csr.csr_addr == c_addr_tid);
  assign w_sel_tcfg  = (csr.csr_addr == c_addr_tcfg);
  assign w_sel_tval  = (csr.csr_addr == c_addr_tval);
  assign w_sel_ticlr = (csr.csr_addr == c_addr_ticlr);

  // State
  logic [12:0]        r_lie;
  logic [1:0]         r_swi;
  logic [31:0]        r_tid;
  logic [TIMER_W-1:0] r_tcfg;
  logic [TIMER_W-1:0] r_tval;
  logic               r_timer_en;
  logic               r_ti;
  logic               r_ipi;
  logic               r_int_pending;
  logic [7:0]         w_hwi_is;
  logic [12:0]        w_is;

  // Hardware interrupt synchronisers
  generate
    if (N_HWI > 0) begin : g_hwi
      logic [c_hwi_w-1:0] r_sync [SYNC_STAGES];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
          r_sync[0] <= hwi;
          for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
      end

      always_comb begin
        w_hwi_is = '0;
        for (int i = 0; i < N_HWI; i++) w_hwi_is[i] = r_sync[SYNC_STAGES-1][i];
      end
    end else begin : g_no_hwi
      assign w_hwi_is = '0;
    end
  endgenerate

  assign w_is = {r_ipi, r_ti, 1'b0, w_hwi_is, r_swi};

  // Software-visible interrupt configuration and identity
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lie <= '0;
      r_swi <= '0;
      r_tid <= 32'(CORE_ID);
      r_ipi <= 1'b0;
    end else begin
      r_ipi <= ipi;
      if (csr.csr_we && w_sel_ecfg)  r_lie <= csr.csr_wdata[12:0] & c_lie_mask;
      if (csr.csr_we && w_sel_estat) r_swi <= csr.csr_wdata[1:0];
      if (csr.csr_we && w_sel_tid)   r_tid <= csr.csr_wdata;
    end
  end

  // Timer
  logic [TIMER_W-1:0] w_reload;
  logic [TIMER_W-1:0] w_new_load;
  logic               w_tcfg_we;
  logic               w_expire;
  logic               w_ticlr;

  assign w_reload   = {r_tcfg[TIMER_W-1:2], 2'b00};
  assign w_new_load = {csr.csr_wdata[TIMER_W-1:2], 2'b00};
  assign w_tcfg_we  = csr.csr_we && w_sel_tcfg;
  assign w_expire   = r_timer_en && (r_tval == '0);
  assign w_ticlr    = csr.csr_we && w_sel_ticlr && csr.csr_wdata[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tcfg     <= '0;
      r_tval     <= '0;
      r_timer_en <= 1'b0;
      r_ti       <= 1'b0;
    end else begin
      // A TCFG write overrides whatever the countdown would have done.
      if (w_tcfg_we) begin
        r_tcfg     <= csr.csr_wdata[TIMER_W-1:0];
        r_tval     <= w_new_load;
        r_timer_en <= csr.csr_wdata[0];
      end else if (r_timer_en) begin
        if (r_tval != '0) begin
          r_tval <= r_tval - c_tval_one;
        end else if (r_tcfg[1]) begin
          r_tval <= w_reload;
        end else begin
          r_tval     <= '1;
          r_timer_en <= 1'b0;
        end
      end
      // Expiry has priority over a same-cycle clear.
      if (w_expire)     r_ti <= 1'b1;
      else if (w_ticlr) r_ti <= 1'b0;
    end
  end

  // Interrupt pending flag
  always_ff @(posedge clk) begin
    if (reset) r_int_pending <= 1'b0;
    else       r_int_pending <= (|(r_lie & w_is)) & crmd_ie;
  end
  assign int_pending = r_int_pending;

  // Read mux
  always_comb begin
    csr.csr_rdata = '0;
    if (w_sel_ecfg)  csr.csr_rdata = {19'd0, r_lie};
    if (w_sel_estat) csr.csr_rdata = {19'd0, w_is};
    if (w_sel_tid)   csr.csr_rdata = r_tid;
    if (w_sel_tcfg)  csr.csr_rdata = 32'(r_tcfg);
    if (w_sel_tval)  csr.csr_rdata = 32'(r_tval);
  end

  assign csr.csr_hit = w_sel_ecfg | w_sel_estat | w_sel_tid |
                       w_sel_tcfg | w_sel_tval  | w_sel_ticlr;

  // Stable counter
`ifdef CSR_TIMER_STABLE_CNT_EN
  logic [63:0] r_cnt;
  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else       r_cnt <= r_cnt + 64'd1;
  end
  assign cnt_lo = r_cnt[31:0];
  assign cnt_hi = r_cnt[63:32];
`else
  assign cnt_lo = '0;
  assign cnt_hi = '0;
`endif

endmodule
`default_nettype wire
